// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready byte output, framing and overrun flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking instead.
module uart_rx #(
    parameter int clks_per_bit = 5200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam int HALF = clks_per_bit / 2;
    localparam logic [CW-1:0] CNT_BIT_LAST = CW'(clks_per_bit - 1);
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        frame_err_q;
    logic        overrun_q;

    logic        rx_meta_q;
    logic        rx_s_q;
    logic        rx_prev_q;

    logic        rx_fall;
    logic        bit_last;
    logic        half_last;
    logic        stop_tick;
    logic        par_bad;
    logic        byte_done;
    logic        accept;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    // Preset to 1 so reset release on an idle line never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_fall   = rx_prev_q & ~rx_s_q;
    assign cnt_d     = cnt_q + 1'b1;
    assign bit_last  = (cnt_q == CNT_BIT_LAST);
    assign half_last = (cnt_q == CNT_HALF_LAST);
    assign stop_tick = (state_q == STOP) && bit_last;
    assign accept    = valid_q & ready;

`ifdef UART_RX_PARITY_EN
    logic par_q;
    logic parity_err_q;

    // Even parity: data bits and parity bit together must XOR to zero.
    assign par_bad    = ^{par_q, shift_q};
    assign parity_err = parity_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign byte_done = stop_tick & rx_s_q & ~par_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rx_fall) begin
                        state_q <= START;
                    end
                end

                START: begin
                    if (half_last) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        state_q <= rx_s_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                DATA: begin
                    if (bit_last) begin
                        cnt_q <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_last) begin
                        cnt_q   <= '0;
                        par_q   <= rx_s_q;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif

                STOP: begin
                    if (bit_last) begin
                        cnt_q       <= '0;
                        frame_err_q <= ~rx_s_q;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_bad;
`endif
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase

            // A completing byte replaces the held one only if the slot is free
            // or being emptied on this very edge; otherwise it is lost.
            if (byte_done) begin
                if (!valid_q || ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (accept) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's uart_tx.
- Samples the asynchronous rx pin on the system clock and deserialises LSB-first frames.
- Presents each received byte on a valid/ready handshake to the consumer, e.g. the memory-mapped I/O or a command FIFO.
- Flags framing and overrun errors.

Parameters:
- clks_per_bit, 5200, system clocks per UART bit (5200 = 325*16, i.e. 9600 baud at 50 MHz); must be >= 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- data  out  8  received byte; stable while valid=1.
- valid  out  1  byte available.
- ready  in  1  consumer accepts byte when valid=1 and ready=1 at a clk edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky: a byte completed while the previous byte was still unaccepted.
- parity_err  out  1  one-cycle pulse on bad parity (see Optional Feature); constant 0 otherwise.

Behaviour:
- Reset (async, active-high): state=IDLE; data=0, valid=0, frame_err=0, overrun=0, parity_err=0; synchroniser flops preset to 1; counters cleared. Reset mid-frame abandons the frame with no output.
- Sync: rx passes through 2 flops (rx_s). Falling-edge detect compares rx_s with its previous value.
- Definitions: C = clks_per_bit; H = C>>1 (floor).
- Cycle 0 is the first cycle rx_s=0 after being 1 while state=IDLE.
- States:
  - IDLE: wait for falling edge; then go to START, clear the bit counter cnt.
  - START: at cnt=H-1 sample rx_s. If 1 (glitch), return to IDLE with no flags. If 0, go to DATA, clear cnt, set bit index to 0.
  - DATA: every C cycles (cnt=C-1) sample rx_s into shift register bit [idx], LSB first. After bit 7 go to STOP (or PARITY when enabled).
  - STOP: at cnt=C-1 sample rx_s. If 1, the byte completes. If 0, frame_err=1 for one cycle and the byte is discarded. Then go to IDLE.
- Sample times relative to cycle 0: start bit at H; data bit n at H+(n+1)*C; stop bit at H+9*C. Byte completion (data updated, valid=1) is visible on the cycle after the stop sample.
- IDLE re-arms only on a fresh 1->0 edge. A line held low after a framing error produces no new frame until rx_s returns high.
- Handshake:
  - valid stays high until a clk edge with valid&ready; valid drops the next cycle.
  - data is never changed while valid=1, except in the simultaneous case below.
- Simultaneous accept and complete (valid&ready in the same cycle as completion): the old byte is accepted, the new byte is loaded, valid stays 1, overrun unchanged.
- Completion while valid=1 and ready=0: the new byte is dropped, data holds the old byte, and overrun is set. overrun clears on the next accepting edge (valid&ready).
- No back-pressure on the line; rx is always sampled.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1.
  - A PARITY state sits between DATA and STOP, sampled at H+9*C; stop moves to H+10*C.
  - If XOR(data bits, parity bit) != 0: parity_err pulses one cycle together with the stop-sample result, and the byte is discarded (valid not set). Frame_err takes independent effect.
- Undefined: 8N1 timing as above; parity_err tied 0; no PARITY state.

Test Plan:
- clks_per_bit=16. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with ready=1 -> valid pulses 1 cycle, data=0xA5, no flags; valid rises at cycle 8+9*16+1 after edge detect.
- rx low for 4 clocks then high -> START rejects the glitch; no valid, no flags; state returns to IDLE.
- Frame 0x3C with stop bit driven 0 -> frame_err 1-cycle pulse, valid stays 0. Line returns high, then 0x3C sent correctly -> data=0x3C.
- ready=0; send 0x11 then 0x22 back-to-back -> after the second frame overrun=1, data=0x11, valid=1. Assert ready for one cycle -> valid=0, overrun=0.
- Assert rst during data bit 4 of 0xFF, release, send 0x5A -> all outputs 0 during reset; only 0x5A delivered.
- UART_RX_PARITY_EN: send 0x07 with parity bit 1 (correct) -> data=0x07. Send 0x07 with parity 0 -> parity_err pulse, no valid.
